pos_emb_csr_slave: RTL and testbench
====================================

// Module: pos_emb_csr_slave
// PURPOSE
//  AXI4-Lite register-file responder for the positional-embedding (RoPE) engine.
//  Accepts the host's Run_PosEmb_Hardware programming sequence: POS/DAT_IN/DAT_OUT
//  base addresses plus head/line strides, then a start write.
//  Drives the config bus and a one-cycle start pulse into the engine.
//  Tracks busy/done and answers status polls until completion.
// PARAMETERS
//  ADDR_W   8   AXI-Lite address width (byte address; low 2 bits ignored)
//  DATA_W   32  AXI-Lite data width; fixed at 32
//  CFG_W    32  width of each base/stride output
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       async active-low reset
//  s_awvalid/awready in/out 1   write-address handshake
//  s_awaddr        in   ADDR_W  write address
//  s_wvalid/wready in/out 1     write-data handshake
//  s_wdata         in   DATA_W  write data; s_wstrb in 4, byte enables
//  s_bvalid/bready out/in 1     write response; s_bresp out 2 (00 OKAY, 10 SLVERR)
//  s_arvalid/arready in/out 1   read address; s_araddr in ADDR_W
//  s_rvalid/rready out/in 1     read data; s_rdata out DATA_W, s_rresp out 2
//  pos_base, pos_line_stride, din_base, din_head_stride, din_line_stride,
//  dout_base, dout_head_stride, dout_line_stride   out CFG_W   engine config
//  emb_start       out  1       one-cycle launch pulse
//  emb_done        in   1       one-cycle completion pulse from engine
// BEHAVIOUR
//  Map: 00 CTRL (W: b0 start, b1 clear done) | 04 STATUS RO (b0 busy, b1 done sticky)
//   08 POS_BASE 0C POS_LINE_STRIDE 10 DIN_BASE 14 DIN_HEAD_STRIDE 18 DIN_LINE_STRIDE
//   1C DOUT_BASE 20 DOUT_HEAD_STRIDE 24 DOUT_LINE_STRIDE. Others: read 0, SLVERR.
//  Reset: all cfg regs 0, busy=0, done=0, emb_start=0, all *ready=0, b/rvalid=0, resp=00.
//  Write FSM WIDLE->{WAW,WW}->WRESP: AW and W captured independently, any order or
//   same cycle; awready/wready high only in states lacking that beat. Register
//   update, bvalid both assert the cycle after the second beat; hold until bready.
//   Next AW/W not accepted until bvalid&bready.
//  wstrb honoured per byte on cfg regs. Writes to 08-24 while busy: ignored, SLVERR.
//  CTRL.start with busy=0: emb_start=1 next cycle, busy=1, done=0. With busy=1:
//   ignored, SLVERR, no pulse. Both CTRL bits set: clear done applies first, then start.
//  emb_done: busy<=0, done<=1 next cycle. emb_done while busy=0: ignored.
//  Same-cycle emb_done and start: start judged on the pre-cycle busy value, so SLVERR.
//  Read FSM RIDLE->RRESP: arready=1 in RIDLE; rdata sampled at AR accept (pre-update
//   state); rvalid next cycle, held until rready. Reads and writes run concurrently.
//  Async reset mid-transaction aborts it; no response is issued for it.
// CONFIGURATION
//  POSEMB_CSR_IRQ_EN defined: adds port irq out 1, = done & IRQ_MASK (reg 28, b0, RW,
//   reset 0). Level output; cleared by CTRL.clear done.
//  Undefined: no irq port. Reg 28 reads 0, SLVERR.
// STRUCTURE
//  pos_emb_csr_pkg: register offset localparams, RESP_OKAY/RESP_SLVERR, wr_state_t
//   and rd_state_t enums, cfg_regs_t struct of the eight CFG_W fields.
//  No sub-module: both FSMs and the register array live in this module.
// TESTING
//  1. Write 08..24 = 0x0400_0000, 0x80, 0, 0x800, 0x80, 0x0800_0000, 0x800, 0x80, each
//     OKAY -> cfg outputs equal the written values; readback matches.
//  2. W beat 3 cycles before AW to 0x1C, data 0x1234_5678 -> single update, one bresp OKAY.
//  3. CTRL=1 -> emb_start high exactly 1 cycle; STATUS=0x1. Pulse emb_done -> STATUS=0x2.
//  4. While busy: write 0x08 and CTRL=1 -> both SLVERR, pos_base unchanged, no emb_start.
//  5. Read 0x30 -> rdata 0, SLVERR. Hold bready/rready low 5 cycles -> valid and data stable.
//  6. Assert rst_n=0 between AW and W beats -> all outputs at reset values; next write completes.

Source files
------------

// File: rtl/pos_emb_csr_pkg.sv
// Shared definitions for the RoPE engine CSR slave: register map, AXI response
// codes, channel FSM state types and the engine configuration bundle.
package pos_emb_csr_pkg;

  localparam logic [7:0] OFF_CTRL             = 8'h00;
  localparam logic [7:0] OFF_STATUS           = 8'h04;
  localparam logic [7:0] OFF_POS_BASE         = 8'h08;
  localparam logic [7:0] OFF_POS_LINE_STRIDE  = 8'h0C;
  localparam logic [7:0] OFF_DIN_BASE         = 8'h10;
  localparam logic [7:0] OFF_DIN_HEAD_STRIDE  = 8'h14;
  localparam logic [7:0] OFF_DIN_LINE_STRIDE  = 8'h18;
  localparam logic [7:0] OFF_DOUT_BASE        = 8'h1C;
  localparam logic [7:0] OFF_DOUT_HEAD_STRIDE = 8'h20;
  localparam logic [7:0] OFF_DOUT_LINE_STRIDE = 8'h24;
  localparam logic [7:0] OFF_IRQ_MASK         = 8'h28;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WAW: W beat held, waiting for AW. WW: AW beat held, waiting for W.
  typedef enum logic [1:0] {WIDLE, WAW, WW, WRESP} wr_state_t;
  typedef enum logic {RIDLE, RRESP} rd_state_t;

  typedef struct packed {
    logic [31:0] pos_base;
    logic [31:0] pos_line_stride;
    logic [31:0] din_base;
    logic [31:0] din_head_stride;
    logic [31:0] din_line_stride;
    logic [31:0] dout_base;
    logic [31:0] dout_head_stride;
    logic [31:0] dout_line_stride;
  } cfg_regs_t;

  // Byte-enable merge of new write data into an existing register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pos_emb_csr_slave.sv
// AXI4-Lite register file driving the positional-embedding engine config bus,
// start pulse and busy/done tracking. Optional irq output and mask register
// are built when POSEMB_CSR_IRQ_EN is defined.
module pos_emb_csr_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CFG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic [CFG_W-1:0]  pos_base,
  output logic [CFG_W-1:0]  pos_line_stride,
  output logic [CFG_W-1:0]  din_base,
  output logic [CFG_W-1:0]  din_head_stride,
  output logic [CFG_W-1:0]  din_line_stride,
  output logic [CFG_W-1:0]  dout_base,
  output logic [CFG_W-1:0]  dout_head_stride,
  output logic [CFG_W-1:0]  dout_line_stride,
`ifdef POSEMB_CSR_IRQ_EN
  output logic              irq,
`endif
  output logic              emb_start,
  input  logic              emb_done
);
  import pos_emb_csr_pkg::*;

  wr_state_t         wr_st, wr_nxt;
  rd_state_t         rd_st, rd_nxt;
  logic              live;
  logic [ADDR_W-1:0] aw_q, wa, ra;
  logic [DATA_W-1:0] w_q, wd, rd_data;
  logic [3:0]        strb_q, ws;
  logic [1:0]        bresp_q, wr_resp, rd_resp;
  logic              aw_hs, w_hs, ar_hs, wr_fire, wr_cfg, do_start, do_clr;
  logic              busy, done;
  cfg_regs_t         cfg, cfg_nxt;
`ifdef POSEMB_CSR_IRQ_EN
  logic              irq_mask, irq_mask_nxt;
  assign irq = done & irq_mask;
`endif

  // Ready outputs stay low while reset is asserted and in the first cycle after.
  assign s_awready = live & ((wr_st == WIDLE) | (wr_st == WAW));
  assign s_wready  = live & ((wr_st == WIDLE) | (wr_st == WW));
  assign s_arready = live & (rd_st == RIDLE);
  assign s_bvalid  = (wr_st == WRESP);
  assign s_rvalid  = (rd_st == RRESP);
  assign s_bresp   = bresp_q;

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign ar_hs   = s_arvalid & s_arready;
  // Effective write beat: live handshake if happening now, else the held beat.
  assign wa      = (aw_hs ? s_awaddr : aw_q) & ~ADDR_W'(3);
  assign wd      = w_hs ? s_wdata : w_q;
  assign ws      = w_hs ? s_wstrb : strb_q;
  assign ra      = s_araddr & ~ADDR_W'(3);
  assign wr_fire = (wr_nxt == WRESP) & (wr_st != WRESP);

  assign pos_base         = CFG_W'(cfg.pos_base);
  assign pos_line_stride  = CFG_W'(cfg.pos_line_stride);
  assign din_base         = CFG_W'(cfg.din_base);
  assign din_head_stride  = CFG_W'(cfg.din_head_stride);
  assign din_line_stride  = CFG_W'(cfg.din_line_stride);
  assign dout_base        = CFG_W'(cfg.dout_base);
  assign dout_head_stride = CFG_W'(cfg.dout_head_stride);
  assign dout_line_stride = CFG_W'(cfg.dout_line_stride);

  // Ready gating flop: goes high one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;

  // Write channel next state: AW and W collected in either order.
  always_comb begin
    wr_nxt = wr_st;
    case (wr_st)
      WIDLE:   if (aw_hs && w_hs) wr_nxt = WRESP;
               else if (aw_hs)    wr_nxt = WW;
               else if (w_hs)     wr_nxt = WAW;
      WAW:     if (aw_hs)         wr_nxt = WRESP;
      WW:      if (w_hs)          wr_nxt = WRESP;
      default: if (s_bready)      wr_nxt = WIDLE;
    endcase
  end

  // Write channel state, held beats and response code.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_st   <= WIDLE;
      aw_q    <= '0;
      w_q     <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      wr_st <= wr_nxt;
      if (aw_hs) aw_q <= s_awaddr;
      if (w_hs) begin
        w_q    <= s_wdata;
        strb_q <= s_wstrb;
      end
      if (wr_fire) bresp_q <= wr_resp;
    end

  // Write decode: next register values, control actions and response.
  always_comb begin
    cfg_nxt  = cfg;
    wr_cfg   = 1'b0;
    do_start = 1'b0;
    do_clr   = 1'b0;
    wr_resp  = RESP_OKAY;
`ifdef POSEMB_CSR_IRQ_EN
    irq_mask_nxt = irq_mask;
`endif
    case (wa)
      ADDR_W'(OFF_CTRL): if (ws[0]) begin
        do_clr = wd[1];
        if (wd[0]) begin
          if (busy) wr_resp  = RESP_SLVERR;
          else      do_start = 1'b1;
        end
      end
      ADDR_W'(OFF_STATUS): ;
      ADDR_W'(OFF_POS_BASE):         begin wr_cfg = 1'b1; cfg_nxt.pos_base         = strb_merge(cfg.pos_base, wd, ws); end
      ADDR_W'(OFF_POS_LINE_STRIDE):  begin wr_cfg = 1'b1; cfg_nxt.pos_line_stride  = strb_merge(cfg.pos_line_stride, wd, ws); end
      ADDR_W'(OFF_DIN_BASE):         begin wr_cfg = 1'b1; cfg_nxt.din_base         = strb_merge(cfg.din_base, wd, ws); end
      ADDR_W'(OFF_DIN_HEAD_STRIDE):  begin wr_cfg = 1'b1; cfg_nxt.din_head_stride  = strb_merge(cfg.din_head_stride, wd, ws); end
      ADDR_W'(OFF_DIN_LINE_STRIDE):  begin wr_cfg = 1'b1; cfg_nxt.din_line_stride  = strb_merge(cfg.din_line_stride, wd, ws); end
      ADDR_W'(OFF_DOUT_BASE):        begin wr_cfg = 1'b1; cfg_nxt.dout_base        = strb_merge(cfg.dout_base, wd, ws); end
      ADDR_W'(OFF_DOUT_HEAD_STRIDE): begin wr_cfg = 1'b1; cfg_nxt.dout_head_stride = strb_merge(cfg.dout_head_stride, wd, ws); end
      ADDR_W'(OFF_DOUT_LINE_STRIDE): begin wr_cfg = 1'b1; cfg_nxt.dout_line_stride = strb_merge(cfg.dout_line_stride, wd, ws); end
`ifdef POSEMB_CSR_IRQ_EN
      ADDR_W'(OFF_IRQ_MASK): if (ws[0]) irq_mask_nxt = wd[0];
`endif
      default: wr_resp = RESP_SLVERR;
    endcase
    // Config is frozen while the engine runs.
    if (wr_cfg && busy) wr_resp = RESP_SLVERR;
  end

  // Register file and engine handshake; a done pulse wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      emb_start <= 1'b0;
`ifdef POSEMB_CSR_IRQ_EN
      irq_mask  <= 1'b0;
`endif
    end else begin
      emb_start <= 1'b0;
      if (wr_fire) begin
        if (!busy) cfg <= cfg_nxt;
        if (do_clr) done <= 1'b0;
        if (do_start) begin
          busy      <= 1'b1;
          done      <= 1'b0;
          emb_start <= 1'b1;
        end
`ifdef POSEMB_CSR_IRQ_EN
        irq_mask <= irq_mask_nxt;
`endif
      end
      if (emb_done && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end

  // Read decode against the current register state.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ra)
      ADDR_W'(OFF_CTRL): ;
      ADDR_W'(OFF_STATUS):           rd_data = DATA_W'({done, busy});
      ADDR_W'(OFF_POS_BASE):         rd_data = cfg.pos_base;
      ADDR_W'(OFF_POS_LINE_STRIDE):  rd_data = cfg.pos_line_stride;
      ADDR_W'(OFF_DIN_BASE):         rd_data = cfg.din_base;
      ADDR_W'(OFF_DIN_HEAD_STRIDE):  rd_data = cfg.din_head_stride;
      ADDR_W'(OFF_DIN_LINE_STRIDE):  rd_data = cfg.din_line_stride;
      ADDR_W'(OFF_DOUT_BASE):        rd_data = cfg.dout_base;
      ADDR_W'(OFF_DOUT_HEAD_STRIDE): rd_data = cfg.dout_head_stride;
      ADDR_W'(OFF_DOUT_LINE_STRIDE): rd_data = cfg.dout_line_stride;
`ifdef POSEMB_CSR_IRQ_EN
      ADDR_W'(OFF_IRQ_MASK):         rd_data = DATA_W'(irq_mask);
`endif
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel next state.
  always_comb begin
    rd_nxt = rd_st;
    case (rd_st)
      RIDLE:   if (ar_hs)    rd_nxt = RRESP;
      default: if (s_rready) rd_nxt = RIDLE;
    endcase
  end

  // Read channel state; data captured at AR accept and held until rready.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_st   <= RIDLE;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else begin
      rd_st <= rd_nxt;
      if (ar_hs) begin
        s_rdata <= rd_data;
        s_rresp <= rd_resp;
      end
    end

endmodule

// File: tb/tb_pos_emb_csr_slave.sv
// Self-checking bench for pos_emb_csr_slave: directed programming sequence,
// boundary cases, then randomized traffic against a register-map model.
module tb_pos_emb_csr_slave;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
  logic        s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
  logic [7:0]  s_awaddr = 0, s_araddr = 0;
  logic [31:0] s_wdata = 0, s_rdata;
  logic [3:0]  s_wstrb = 0;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] pos_base, pos_line_stride, din_base, din_head_stride, din_line_stride;
  logic [31:0] dout_base, dout_head_stride, dout_line_stride;
  logic        emb_start, emb_done = 0;
`ifdef POSEMB_CSR_IRQ_EN
  logic        irq;
`endif

  pos_emb_csr_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .pos_base(pos_base), .pos_line_stride(pos_line_stride),
    .din_base(din_base), .din_head_stride(din_head_stride), .din_line_stride(din_line_stride),
    .dout_base(dout_base), .dout_head_stride(dout_head_stride), .dout_line_stride(dout_line_stride),
`ifdef POSEMB_CSR_IRQ_EN
    .irq(irq),
`endif
    .emb_start(emb_start), .emb_done(emb_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int start_cnt = 0, exp_starts = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count high cycles of the launch pulse.
  always @(negedge clk) if (emb_start === 1'b1) start_cnt++;

  // ---------------- reference model: register map as plain arrays ----------
  logic [31:0] m_cfg [8];
  bit          m_busy, m_done, m_mask;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cfg[i] = 0;
    m_busy = 0; m_done = 0; m_mask = 0;
  endtask

  task automatic model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int w;
    w = a / 4;
    resp = 2'b00;
    if (w == 0) begin
      if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[0]) begin
          if (m_busy) resp = 2'b10;
          else begin m_busy = 1; m_done = 0; exp_starts++; end
        end
      end
    end else if (w == 1) begin
      resp = 2'b00;
    end else if (w >= 2 && w <= 9) begin
      if (m_busy) resp = 2'b10;
      else for (int b = 0; b < 4; b++)
        if (s[b]) m_cfg[w-2][b*8 +: 8] = d[b*8 +: 8];
    end else begin
`ifdef POSEMB_CSR_IRQ_EN
      if (w == 10) begin if (s[0]) m_mask = d[0]; end
      else resp = 2'b10;
`else
      resp = 2'b10;
`endif
    end
  endtask

  task automatic model_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int w;
    w = a / 4;
    d = 0; resp = 2'b00;
    if (w == 1) d = {30'd0, m_done, m_busy};
    else if (w >= 2 && w <= 9) d = m_cfg[w-2];
`ifdef POSEMB_CSR_IRQ_EN
    else if (w == 10) d = {31'd0, m_mask};
`endif
    else if (w != 0) resp = 2'b10;
  endtask

  // ---------------- bus tasks (inputs driven off the active edge) ----------
  task automatic send_aw(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1;
    while (!s_awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("awready_timeout", 0, 1);
    @(posedge clk); #1 s_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    s_wdata = d; s_wstrb = s; s_wvalid = 1;
    while (!s_wready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("wready_timeout", 0, 1);
    @(posedge clk); #1 s_wvalid = 0;
  endtask

  task automatic send_both(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = s; s_wvalid = 1;
    while (!(s_awready && s_wready) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("awwready_timeout", 0, 1);
    @(posedge clk); #1 begin s_awvalid = 0; s_wvalid = 0; end
  endtask

  // mode 0: same cycle, 1: AW then W, 2: W then AW. lat = cycles to bvalid after last beat.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input int gap, input int bstall,
                    output logic [1:0] resp, output int lat);
    int n = 0;
    logic [1:0] r0;
    if (mode == 0) send_both(a, d, s);
    else if (mode == 1) begin send_aw(a); repeat (gap) @(negedge clk); send_w(d, s); end
    else begin send_w(d, s); repeat (gap) @(negedge clk); send_aw(a); end
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    lat = n;
    if (n >= 20) chk("bvalid_timeout", 0, 1);
    r0 = s_bresp;
    for (int i = 0; i < bstall; i++) begin
      @(negedge clk);
      chk("bvalid_hold", s_bvalid, 1);
      chk("bresp_hold", s_bresp, r0);
    end
    resp = s_bresp;
    s_bready = 1;
    @(posedge clk); #1 s_bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, input int rstall,
                    output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    logic [31:0] d0;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("arready_timeout", 0, 1);
    @(posedge clk); #1 s_arvalid = 0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("rvalid_timeout", 0, 1);
    d0 = s_rdata;
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      chk("rvalid_hold", s_rvalid, 1);
      chk("rdata_hold", s_rdata, d0);
    end
    d = s_rdata; resp = s_rresp;
    s_rready = 1;
    @(posedge clk); #1 s_rready = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk); emb_done = 1;
    @(negedge clk); emb_done = 0;
    if (m_busy) begin m_busy = 0; m_done = 1; end
  endtask

  // Model-checked write / read helpers.
  task automatic cwr(input string tag, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode, input int gap);
    logic [1:0] r, er;
    int lat;
    model_wr(a, d, s, er);
    wr(a, d, s, mode, gap, 0, r, lat);
    chk(tag, r, er);
  endtask

  task automatic crd(input string tag, input logic [7:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    model_rd(a, ed, er);
    rd(a, 0, d, r);
    chk({tag, "_data"}, d, ed);
    chk({tag, "_resp"}, r, er);
  endtask

  function automatic logic [255:0] cfg_out();
    return {pos_base, pos_line_stride, din_base, din_head_stride, din_line_stride,
            dout_base, dout_head_stride, dout_line_stride};
  endfunction

  task automatic chk_cfg(input string tag);
    for (int i = 0; i < 8; i++) begin
      logic [255:0] v;
      v = cfg_out();
      chk(tag, v[(7-i)*32 +: 32], m_cfg[i]);
    end
  endtask

  logic [31:0] prog_vals [8] = '{32'h0400_0000, 32'h80, 32'h0, 32'h800,
                                  32'h80, 32'h0800_0000, 32'h800, 32'h80};

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int lat, c0;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_wready",  s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid",  s_bvalid, 0);
    chk("rst_rvalid",  s_rvalid, 0);
    chk("rst_resp",    {s_bresp, s_rresp}, 0);
    chk("rst_start",   emb_start, 0);
    chk("rst_cfg",     cfg_out(), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Programming sequence with readback.
    for (int i = 0; i < 8; i++) cwr("prog_resp", 8'(8 + 4*i), prog_vals[i], 4'hF, i % 3, 1);
    chk_cfg("prog_cfg");
    for (int i = 0; i < 8; i++) crd("prog_rd", 8'(8 + 4*i));

    // W three cycles ahead of AW; update and bvalid together, single response.
    model_wr(8'h1C, 32'h1234_5678, 4'hF, r);
    send_w(32'h1234_5678, 4'hF);
    repeat (3) @(negedge clk);
    chk("wfirst_no_b", s_bvalid, 0);
    chk("wfirst_no_upd", dout_base, 32'h0800_0000);
    send_aw(8'h1C);
    chk("wfirst_bvalid", s_bvalid, 1);
    chk("wfirst_upd", dout_base, 32'h1234_5678);
    chk("wfirst_resp", s_bresp, 2'b00);
    s_bready = 1; @(posedge clk); #1 s_bready = 0;
    @(negedge clk);
    chk("wfirst_single_b", s_bvalid, 0);

    // Launch and completion.
    c0 = start_cnt;
    cwr("start_resp", 8'h00, 32'h1, 4'hF, 0, 0);
    repeat (2) @(negedge clk);
    chk("start_pulse", start_cnt - c0, 1);
    crd("status_busy", 8'h04);
    // While busy: config write and restart are refused.
    cwr("busy_cfg_resp", 8'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
    chk("busy_cfg_hold", pos_base, 32'h0400_0000);
    cwr("busy_start_resp", 8'h00, 32'h1, 4'hF, 1, 2);
    repeat (2) @(negedge clk);
    chk("busy_no_pulse", start_cnt - c0, 1);
    pulse_done();
    crd("status_done", 8'h04);
    // Byte strobes on a config register.
    cwr("strb_resp", 8'h10, 32'hAABB_CCDD, 4'b0101, 2, 0);
    chk_cfg("strb_cfg");

    // Unmapped read and write with stalled ready.
    model_rd(8'h30, d, r);
    rd(8'h30, 5, d, r);
    chk("unmapped_rdata", d, 0);
    chk("unmapped_rresp", r, 2'b10);
    wr(8'h30, 32'h5, 4'hF, 0, 0, 5, r, lat);
    chk("unmapped_bresp", r, 2'b10);

    // Reset between AW and W aborts the write.
    send_aw(8'h14);
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_ready", {s_awready, s_wready, s_arready}, 0);
    chk("mid_rst_cfg", cfg_out(), 0);
    chk("mid_rst_start", emb_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_bvalid", s_bvalid, 0);
    cwr("post_rst_wr", 8'h14, 32'h0000_0C00, 4'hF, 1, 0);
    crd("post_rst_rd", 8'h14);

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      int op;
      logic [7:0]  a;
      logic [31:0] wdv;
      logic [3:0]  sv;
      op = $urandom_range(0, 99);
      a  = 8'($urandom_range(0, 12) * 4);
      if (op < 50) begin
        wdv = (a == 8'h00) ? 32'($urandom_range(0, 3)) : $urandom;
        sv  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        cwr("rnd_wr", a, wdv, sv, $urandom_range(0, 2), $urandom_range(0, 3));
      end else if (op < 85) begin
        crd("rnd_rd", a);
      end else begin
        pulse_done();
      end
    end
    repeat (2) @(negedge clk);
    chk_cfg("rnd_cfg");
    chk("rnd_starts", start_cnt, exp_starts);
    crd("rnd_status", 8'h04);
`ifdef POSEMB_CSR_IRQ_EN
    chk("rnd_irq", irq, m_done & m_mask);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
